// File: rtl/clk_div_ctrl.sv
// Run-time divide-ratio controller: holds the active ratio, accepts new ratios over valid/ready,
// and applies them only at period boundaries. Produces a registered divided level and period tick.

module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             div_out,
    output logic             tick,
    output logic [CNT_W-1:0] active_div,
    output logic             pending,
    output logic             running
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);

    // Ratios below 2 cannot form a high and a low phase, so they are raised to 2.
    function automatic logic [CNT_W-1:0] coerce_div(input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] r;
        if (d < DIV_MIN) begin
            r = DIV_MIN;
        end else begin
            r = d;
        end
        return r;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] active_div_r, active_div_s;
    logic [CNT_W-1:0] pend_div_r, pend_div_s;
    logic             pending_r, pending_s;
    logic             div_out_r, div_out_s;
    logic             tick_r, tick_s;
    logic             xfer_s;
    logic             wrap_s;

    // Next-state, counter, ratio bookkeeping and next registered outputs.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        active_div_s = active_div_r;
        pend_div_s   = pend_div_r;
        pending_s    = pending_r;
        xfer_s       = div_valid & ~pending_r;
        wrap_s       = (cnt_r == (active_div_r - CNT_ONE));

        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                // No period is in flight, so any ratio goes straight into force.
                if (pending_r) begin
                    active_div_s = pend_div_r;
                    pending_s    = 1'b0;
                end else if (xfer_s) begin
                    active_div_s = coerce_div(div_in);
                end else begin
                    active_div_s = active_div_r;
                end
                if (enable) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (wrap_s) begin
                    cnt_s = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
                // xfer_s and pending_r are mutually exclusive, so a transfer at a wrap waits a period.
                if (wrap_s && pending_r) begin
                    active_div_s = pend_div_r;
                    pending_s    = 1'b0;
                end else if (xfer_s) begin
                    pend_div_s = coerce_div(div_in);
                    pending_s  = 1'b1;
                end else begin
                    pending_s = pending_r;
                end
                if (enable) begin
                    state_s = ST_RUN;
                end else if (wrap_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        div_out_s = (state_r != ST_IDLE) && (cnt_r < (active_div_r >> 1));
        tick_s    = (state_r != ST_IDLE) && (cnt_r == CNT_ZERO);
    end

    // State and period counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Active and pending ratio registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active_div_r <= DIV_RST;
            pend_div_r   <= DIV_RST;
            pending_r    <= 1'b0;
        end else begin
            active_div_r <= active_div_s;
            pend_div_r   <= pend_div_s;
            pending_r    <= pending_s;
        end
    end

    // Registered divided level and period tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_out_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            div_out_r <= div_out_s;
            tick_r    <= tick_s;
        end
    end

    assign div_ready  = ~pending_r;
    assign div_out    = div_out_r;
    assign tick       = tick_r;
    assign active_div = active_div_r;
    assign pending    = pending_r;
    assign running    = (state_r != ST_IDLE);

    clk_div_ctrl_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cnt_r),
        .active_div (active_div_r),
        .pending    (pending_r),
        .div_ready  (div_ready)
    );

endmodule

// Structural invariants of the controller, kept apart from the datapath.
module clk_div_ctrl_chk #(
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] active_div,
    input logic             pending,
    input logic             div_ready
);

    a_div_min: assert property (@(posedge clk) disable iff (!rst) active_div >= CNT_W'(2));
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst) cnt < active_div);
    a_ready: assert property (@(posedge clk) disable iff (!rst) div_ready == ~pending);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with hand-computed expected sequences.

module tb_clk_div_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] div_in;
    logic       div_valid;
    logic       div_ready;
    logic       div_out;
    logic       tick;
    logic [7:0] active_div;
    logic       pending;
    logic       running;

    int n_tests = 0;
    int n_fail  = 0;

    // Ratio change 4 -> 6 -> 9 across boundaries, steps S1..S10.
    int chg_do  [10] = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    int chg_tk  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    int chg_pd  [10] = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 0};
    int chg_act [10] = '{4, 4, 6, 6, 6, 6, 6, 6, 9, 9};
    // N=5 from first RUN cycle.
    int n5_do   [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    int n5_tk   [10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    // N=8 drain from cnt=1.
    int dr_run  [7]  = '{1, 1, 1, 1, 1, 1, 0};
    int dr_do   [7]  = '{1, 1, 1, 0, 0, 0, 0};
    // N=8 re-enable mid-drain, steps E2..E9.
    int re_do   [8]  = '{1, 1, 1, 0, 0, 0, 0, 1};
    int re_tk   [8]  = '{0, 0, 0, 0, 0, 0, 0, 1};

    clk_div_ctrl #(
        .CNT_W       (8),
        .DEFAULT_DIV (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .div_in     (div_in),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_out    (div_out),
        .tick       (tick),
        .active_div (active_div),
        .pending    (pending),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && running; i++) begin
            step();
        end
        check_eq(tag, int'(running), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_div_out"}, int'(div_out), 0);
        check_eq({tag, "_tick"}, int'(tick), 0);
        check_eq({tag, "_active"}, int'(active_div), 2);
        check_eq({tag, "_pending"}, int'(pending), 0);
        check_eq({tag, "_ready"}, int'(div_ready), 1);
        check_eq({tag, "_running"}, int'(running), 0);
    endtask

    initial begin
        rst       = 1'b0;
        enable    = 1'b0;
        div_in    = 8'd0;
        div_valid = 1'b0;
        step();
        step();
        check_reset_vals("rst");

        // Default N=2.
        rst = 1'b1;
        step();
        enable = 1'b1;
        step();
        check_eq("n2_running", int'(running), 1);
        check_eq("n2_first_tick", int'(tick), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq($sformatf("n2_do%0d", i), int'(div_out), (i % 2 == 0) ? 1 : 0);
            check_eq($sformatf("n2_tk%0d", i), int'(tick), (i % 2 == 0) ? 1 : 0);
        end
        enable = 1'b0;
        step();
        step();
        step();
        check_eq("n2_idle_running", int'(running), 0);
        check_eq("n2_idle_div_out", int'(div_out), 0);

        // Ratio 5 loaded in IDLE.
        div_in    = 8'd5;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        check_eq("n5_active", int'(active_div), 5);
        check_eq("n5_pending", int'(pending), 0);
        enable = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("n5_do%0d", i), int'(div_out), n5_do[i]);
            check_eq($sformatf("n5_tk%0d", i), int'(tick), n5_tk[i]);
        end
        enable = 1'b0;
        wait_idle("n5_drain_idle");

        // Transfer coinciding with enable rising: ratio 4 applies to first period.
        div_in    = 8'd4;
        div_valid = 1'b1;
        enable    = 1'b1;
        step();
        div_valid = 1'b0;
        check_eq("n4_active", int'(active_div), 4);
        check_eq("n4_pending", int'(pending), 0);
        step();
        div_in    = 8'd6;
        div_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin
                div_in = 8'd9;
            end else if (i == 3) begin
                div_valid = 1'b0;
            end else begin
                div_valid = div_valid;
            end
            check_eq($sformatf("chg_do%0d", i), int'(div_out), chg_do[i]);
            check_eq($sformatf("chg_tk%0d", i), int'(tick), chg_tk[i]);
            check_eq($sformatf("chg_pend%0d", i), int'(pending), chg_pd[i]);
            check_eq($sformatf("chg_ready%0d", i), int'(div_ready), 1 - chg_pd[i]);
            check_eq($sformatf("chg_act%0d", i), int'(active_div), chg_act[i]);
        end
        enable = 1'b0;
        wait_idle("chg_drain_idle");

        // Coercion of 0 and 1 to 2.
        div_valid = 1'b1;
        div_in    = 8'd0;
        step();
        check_eq("coerce0", int'(active_div), 2);
        div_in = 8'd7;
        step();
        check_eq("load7", int'(active_div), 7);
        div_in = 8'd1;
        step();
        check_eq("coerce1", int'(active_div), 2);
        div_in = 8'd8;
        step();
        div_valid = 1'b0;
        check_eq("load8", int'(active_div), 8);

        // Drain from cnt=1 of N=8.
        enable = 1'b1;
        step();
        step();
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq($sformatf("dr_run%0d", i), int'(running), dr_run[i]);
            check_eq($sformatf("dr_do%0d", i), int'(div_out), dr_do[i]);
            check_eq($sformatf("dr_tk%0d", i), int'(tick), 0);
        end

        // Re-enable mid-drain: no gap, period stays 8.
        enable = 1'b1;
        step();
        step();
        check_eq("re_first_tick", int'(tick), 1);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                enable = 1'b1;
            end else begin
                enable = enable;
            end
            step();
            check_eq($sformatf("re_run%0d", i), int'(running), 1);
            check_eq($sformatf("re_do%0d", i), int'(div_out), re_do[i]);
            check_eq($sformatf("re_tk%0d", i), int'(tick), re_tk[i]);
        end

        // Reset mid-period with a pending ratio.
        div_in    = 8'd3;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        check_eq("pre_rst_pending", int'(pending), 1);
        check_eq("pre_rst_div_out", int'(div_out), 1);
        rst = 1'b0;
        step();
        check_reset_vals("mid_rst");
        rst = 1'b1;
        step();
        step();
        check_eq("post_rst_do", int'(div_out), 1);
        check_eq("post_rst_tk", int'(tick), 1);
        step();
        check_eq("post_rst_do2", int'(div_out), 0);
        step();
        check_eq("post_rst_active", int'(active_div), 2);
        check_eq("post_rst_pending", int'(pending), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
